// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the APB-to-SPI flash controller: FSM states,
// default datapath widths and the minimum SCK half period.
package spi_ctrl_pkg;

   localparam int unsigned DIV_W_DEF = 15;
   localparam int unsigned CNT_W_DEF = 8;
   localparam int unsigned HALF_MIN  = 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_RUN   = 3'd2,
      S_HOLD  = 3'd3,
      S_DONE  = 3'd4
   } spi_state_t;

endpackage

// File: rtl/sclk_tick_gen.sv
// Half-period tick generator: latches H = n_div/2 (minimum 1) on load and
// pulses tick_c every H cycles of clkin.
module sclk_tick_gen
   import spi_ctrl_pkg::*;
#(
   parameter int unsigned DIV_W = DIV_W_DEF
) (
   input  logic             clkin,
   input  logic             reset,
   input  logic             load,
   input  logic             clear,
   input  logic [DIV_W-1:0] n_div,
   output logic             tick_c
);

   logic [DIV_W-1:0] half;
   logic [DIV_W-1:0] hcnt;

   assign tick_c = (hcnt == half - DIV_W'(1));

   always_ff @(posedge clkin) begin
      if (reset) begin
         half <= DIV_W'(HALF_MIN);
         hcnt <= '0;
      end else begin
         if (load)
            half <= (n_div < DIV_W'(2)) ? DIV_W'(HALF_MIN) : (n_div >> 1);
         // every state transition happens on a tick, so wrapping here also
         // restarts the count on state entry
         if (clear || load || tick_c)
            hcnt <= '0;
         else
            hcnt <= hcnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/spi_sclk_sched.sv
// SPI transfer sequencer: chip select, edge-counted SCK synchronous to clkin,
// and one-cycle shift/sample strobes for the shifter.
module spi_sclk_sched
   import spi_ctrl_pkg::*;
#(
   parameter int unsigned DIV_W = DIV_W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clkin,
   input  logic             reset,
   input  logic             start,
   input  logic [DIV_W-1:0] n_div,
   input  logic [CNT_W-1:0] nbits,
   input  logic             cpol,
   input  logic             cpha,
   output logic             busy,
   output logic             cs_n,
   output logic             sclk,
   output logic             shift_stb,
   output logic             sample_stb,
   output logic             done
);

   spi_state_t       state;
   logic [CNT_W-1:0] nbits_q;
   logic             cpha_q;
   logic [CNT_W:0]   ec;
   logic [CNT_W:0]   ec_nxt_c;
   logic [CNT_W:0]   e_tgt_c;
   logic             tick_c;
   logic             load_c;
   logic             clear_c;

   assign ec_nxt_c = ec + (CNT_W+1)'(1);
   assign e_tgt_c  = {nbits_q, 1'b0};
   assign load_c   = (state == S_IDLE) && start;
   assign clear_c  = (state == S_IDLE) || (state == S_DONE);

   sclk_tick_gen #(.DIV_W(DIV_W)) u_tick (
      .clkin  (clkin),
      .reset  (reset),
      .load   (load_c),
      .clear  (clear_c),
      .n_div  (n_div),
      .tick_c (tick_c)
   );

   always_ff @(posedge clkin) begin
      if (reset) begin
         state      <= S_IDLE;
         busy       <= 1'b0;
         cs_n       <= 1'b1;
         sclk       <= 1'b0;
         shift_stb  <= 1'b0;
         sample_stb <= 1'b0;
         done       <= 1'b0;
         ec         <= '0;
         nbits_q    <= '0;
         cpha_q     <= 1'b0;
      end else begin
         shift_stb  <= 1'b0;
         sample_stb <= 1'b0;
         done       <= 1'b0;
         case (state)
            S_IDLE: begin
               sclk <= cpol;
               ec   <= '0;
               if (start) begin
                  nbits_q   <= nbits;
                  cpha_q    <= cpha;
                  cs_n      <= 1'b0;
                  busy      <= 1'b1;
                  // mode 0 presents the first bit as chip select falls
                  shift_stb <= !cpha && (nbits != '0);
                  state     <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (tick_c)
                  state <= (nbits_q == '0) ? S_HOLD : S_RUN;
            end
            S_RUN: begin
               if (tick_c) begin
                  sclk <= ~sclk;
                  ec   <= ec_nxt_c;
                  if (ec_nxt_c[0]) begin
                     if (cpha_q) shift_stb  <= 1'b1;
                     else        sample_stb <= 1'b1;
                  end else begin
                     if (cpha_q)                     sample_stb <= 1'b1;
                     else if (ec_nxt_c != e_tgt_c)   shift_stb  <= 1'b1;
                  end
                  if (ec_nxt_c == e_tgt_c)
                     state <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (tick_c) begin
                  cs_n  <= 1'b1;
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
